uk101_load_sequencer: RTL and testbench
=======================================

# uk101_load_sequencer

Sequences program text into the UK101 ACIA receive path from one of two sources: bytes streamed by the HPS file loader (TXT/BAS/LOD menu entry) or the external UART receiver. File bytes are buffered in a small FIFO. They are back-pressured to the HPS with `ioctl_wait` and released to the ACIA at the selected baud rate, with an extra pause after each carriage return so BASIC/monitor line entry keeps up. It sits inside `uk101`, between the hps_io download bus / UART receiver and the ACIA receive-data input.

## Interface
Parameters:
- `CLK_HZ`, 48000000, system clock frequency.
- `FIFO_DEPTH`, 16, file-byte FIFO entries; power of two, at least 4.
- `CR_EXTRA_CYCLES`, 2400000, added gap after a CR byte (50 ms at 48 MHz).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `n_reset`  in  1  asynchronous, active-low reset.
- `load_from`  in  1  0 = file, 1 = UART; sampled only in IDLE.
- `baud_rate`  in  1  0 = 9600, 1 = 300; sampled at the start of each gap.
- `ioctl_download`  in  1  HPS download active.
- `ioctl_wr`  in  1  one-cycle strobe; `ioctl_data` is valid.
- `ioctl_data`  in  8  downloaded byte.
- `ioctl_wait`  out  1  stall request to the HPS.
- `uart_rx_valid`  in  1  UART byte strobe.
- `uart_rx_data`  in  8  UART byte.
- `rx_valid`  out  1  byte offered to the ACIA.
- `rx_data`  out  8  byte to the ACIA.
- `rx_ready`  in  1  ACIA accepts; a transfer occurs when `rx_valid & rx_ready`.
- `busy`  out  1  high in any state other than IDLE.
- `overflow`  out  1  sticky flag: a file byte was dropped; cleared by reset only.

## Operation
- States: IDLE, FILE_WAIT, FILE_SEND, FILE_GAP, UART_PASS.
- IDLE:
  - `load_from`=0 and `ioctl_download` rising → FILE_WAIT.
  - `load_from`=1 and `uart_rx_valid` → UART_PASS with the byte latched.
- FILE_WAIT:
  - FIFO non-empty → pop, latch the byte into `rx_data`, go to FILE_SEND.
  - FIFO empty and `ioctl_download`=0 → IDLE.
- FILE_SEND: `rx_valid`=1 until `rx_ready`, then load the gap counter and go to FILE_GAP.
- FILE_GAP:
  - Count down to 0, then go to FILE_WAIT.
  - Gap = CLK_HZ*10/9600 (50000) or CLK_HZ*10/300 (1600000) cycles.
  - Add CR_EXTRA_CYCLES when the sent byte was 0x0D.
- UART_PASS: present the latched byte until `rx_ready`, then return to IDLE. No pacing is applied, because the UART is already baud-paced. UART bytes arriving while `rx_valid`=1 are dropped.
- FIFO push: `ioctl_wr` while `ioctl_download` and the block is in a file state (or in IDLE with `load_from`=0).
  - `ioctl_wr` in UART mode is ignored; no push and no overflow.
  - Push when full: the byte is dropped and `overflow` is set.
- `ioctl_wait` = registered (count ≥ FIFO_DEPTH-2). This leaves two slots for in-flight strobes.
- Simultaneous push and pop: both happen and the count is unchanged.
- Gap counter width: clog2 of the maximum gap value; computed in the package, no truncation.
- `load_from` changes outside IDLE take effect only on return to IDLE.
- A new `ioctl_download` rise during a file load continues the same session; the FIFO is not flushed.

## Timing
- All outputs are 0 at reset: `rx_valid`, `rx_data`=0x00, `ioctl_wait`, `busy`, `overflow`; FIFO empty; state IDLE.
- Asserting reset mid-transfer aborts immediately. The FIFO contents and the gap are discarded.
- Latency: `ioctl_wr` in cycle N → FIFO count visible at N+1 → pop at N+1 → `rx_valid` at N+2 (FIFO previously empty, state FILE_WAIT).
- Back-to-back file bytes: the next `rx_valid` rises exactly gap+1 cycles after the accepting cycle.
- `rx_data` is stable while `rx_valid`=1.
- `ioctl_wait` lags the count by one cycle.

## Configuration
- `UK101_LF_TO_CR_EN` defined:
  - Popped 0x0A is sent as 0x0D.
  - A 0x0A immediately following a sent 0x0D is discarded: no send and no gap, straight back to FILE_WAIT.
  - The CR extra gap applies to converted bytes.
- Undefined: file bytes pass unchanged, and only real 0x0D bytes get the extra gap.
- UART_PASS is never translated.

## Structure
- Package `uk101_load_pkg`:
  - state enum `load_state_t`.
  - constants `ASCII_CR`=8'h0D and `ASCII_LF`=8'h0A.
  - gap cycle constants and the counter width function.
- Sub-module `uk101_load_fifo`: synchronous FIFO (DEPTH, 8-bit) with push, pop, dout, count, full and empty. The sequencer FSM, gap counter and translation logic stay in the top module.

## Test plan
- File mode, 9600: download "AB" → `rx_data` 0x41, then 0x42, with accepts spaced exactly 50001 cycles apart; `busy` falls after the last gap once the download has ended.
- File mode, CR: byte 0x0D at 300 baud → next `rx_valid` 1600000+2400000+1 cycles after the accept.
- Back-pressure: 20 strobes with `rx_ready`=0 and honouring `ioctl_wait` → `ioctl_wait` rises at count 14, `overflow` stays 0, and all 20 bytes are delivered in order. Ignoring `ioctl_wait` → `overflow`=1.
- `UK101_LF_TO_CR_EN`: file "X\r\nY\n" → delivered X, CR, Y, CR. Without the macro → X, CR, LF, Y, LF.
- UART mode: `uart_rx_valid` with 0x55 and `rx_ready`=1 → `rx_valid` for one cycle with 0x55, back to IDLE; concurrent `ioctl_wr` produces no output and no overflow.
- Reset mid-gap with 3 bytes queued → all outputs 0 the same cycle; after release, no stale bytes are emitted.

Source files
------------

// File: rtl/uk101_load_pkg.sv
// Shared types and constants for the UK101 load sequencer: FSM state encoding,
// ASCII control bytes and the baud gap cycle counts.
package uk101_load_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILE_WAIT,
    FILE_SEND,
    FILE_GAP,
    UART_PASS
  } load_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // One 10-bit character time at the given baud rate.
  function automatic int unsigned gap_9600(input int unsigned clk_hz);
    return clk_hz * 10 / 9600;
  endfunction

  function automatic int unsigned gap_300(input int unsigned clk_hz);
    return clk_hz * 10 / 300;
  endfunction

  function automatic int unsigned gap_width(input int unsigned clk_hz,
                                            input int unsigned cr_extra);
    return $clog2(gap_300(clk_hz) + cr_extra + 1);
  endfunction

endpackage

// File: rtl/uk101_load_sequencer_if.sv
// Download/UART/ACIA byte bus of the load sequencer. The master is the
// surrounding system and the slave is the sequencer.
interface uk101_load_sequencer_if;
  logic       ioctl_download;
  logic       ioctl_wr;
  logic [7:0] ioctl_data;
  logic       ioctl_wait;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_data, uart_rx_valid, uart_rx_data, rx_ready,
    input  ioctl_wait, rx_valid, rx_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_data, uart_rx_valid, uart_rx_data, rx_ready,
    output ioctl_wait, rx_valid, rx_data
  );
endinterface

// File: rtl/uk101_load_fifo.sv
// Synchronous byte FIFO buffering downloaded file bytes; push when full and
// pop when empty are ignored.
module uk101_load_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uk101_load_sequencer.sv
// Feeds the UK101 ACIA receive path from the HPS file loader (FIFO-buffered,
// baud-paced) or the UART. Optional macro UK101_LF_TO_CR_EN maps file LF to CR.
module uk101_load_sequencer
  import uk101_load_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 48000000,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned CR_EXTRA_CYCLES = 2400000
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         load_from,
  input  logic                         baud_rate,
  uk101_load_sequencer_if.slave        bus,
  output logic                         busy,
  output logic                         overflow
);
  localparam int unsigned GW = gap_width(CLK_HZ, CR_EXTRA_CYCLES);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  // Loaded two short so the next rx_valid lands gap+1 cycles after the accept.
  localparam logic [GW-1:0] LOAD_9600 = GW'(gap_9600(CLK_HZ) - 2);
  localparam logic [GW-1:0] LOAD_300  = GW'(gap_300(CLK_HZ) - 2);
  localparam logic [GW-1:0] CR_EXTRA  = GW'(CR_EXTRA_CYCLES);

  load_state_t   state, state_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [7:0]    data_q, data_n;
  logic          dl_q;
  logic          wait_q;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
`ifdef UK101_LF_TO_CR_EN
  logic          prev_cr, prev_cr_n;
`endif

  assign fifo_push = bus.ioctl_wr & bus.ioctl_download &
                     ((state inside {FILE_WAIT, FILE_SEND, FILE_GAP}) ||
                      (state == IDLE && !load_from));

  uk101_load_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (fifo_push),
    .din     (bus.ioctl_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rx_valid   = (state == FILE_SEND) || (state == UART_PASS);
  assign bus.rx_data    = data_q;
  assign bus.ioctl_wait = wait_q;
  assign busy           = (state != IDLE);

  always_comb begin
    state_n  = state;
    gap_n    = gap_cnt;
    data_n   = data_q;
    fifo_pop = 1'b0;
`ifdef UK101_LF_TO_CR_EN
    prev_cr_n = prev_cr;
`endif
    case (state)
      IDLE: begin
        if (!load_from && bus.ioctl_download && !dl_q) begin
          state_n = FILE_WAIT;
`ifdef UK101_LF_TO_CR_EN
          prev_cr_n = 1'b0;
`endif
        end else if (load_from && bus.uart_rx_valid) begin
          state_n = UART_PASS;
          data_n  = bus.uart_rx_data;
        end
      end
      FILE_WAIT: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef UK101_LF_TO_CR_EN
          // LF of a CRLF pair is swallowed without a send or a gap.
          if (prev_cr && fifo_dout == ASCII_LF) begin
            prev_cr_n = 1'b0;
          end else begin
            data_n    = (fifo_dout == ASCII_LF) ? ASCII_CR : fifo_dout;
            prev_cr_n = (data_n == ASCII_CR);
            state_n   = FILE_SEND;
          end
`else
          data_n  = fifo_dout;
          state_n = FILE_SEND;
`endif
        end else if (!bus.ioctl_download) begin
          state_n = IDLE;
        end
      end
      FILE_SEND: begin
        if (bus.rx_ready) begin
          state_n = FILE_GAP;
          gap_n   = (baud_rate ? LOAD_300 : LOAD_9600) +
                    ((data_q == ASCII_CR) ? CR_EXTRA : '0);
        end
      end
      FILE_GAP: begin
        if (gap_cnt == '0) state_n = FILE_WAIT;
        else               gap_n   = gap_cnt - GW'(1);
      end
      UART_PASS: begin
        if (bus.rx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      data_q   <= '0;
      dl_q     <= 1'b0;
      wait_q   <= 1'b0;
      overflow <= 1'b0;
`ifdef UK101_LF_TO_CR_EN
      prev_cr  <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      data_q  <= data_n;
      dl_q    <= bus.ioctl_download;
      wait_q  <= (fifo_count >= CW'(FIFO_DEPTH - 2));
      if (fifo_push && fifo_full) overflow <= 1'b1;
`ifdef UK101_LF_TO_CR_EN
      prev_cr <= prev_cr_n;
`endif
    end
  end
endmodule

// File: tb/tb_uk101_load_sequencer.sv
// Scoreboard bench for uk101_load_sequencer with scaled-down clock/gap parameters.
module tb_uk101_load_sequencer;
  localparam int unsigned G96 = 50;    // 48000*10/9600
  localparam int unsigned G3  = 1600;  // 48000*10/300
  localparam int unsigned CRX = 240;

  typedef struct {
    logic [7:0] data;
    longint     spacing;  // 0 = spacing not checked
  } exp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic load_from = 1'b0;
  logic baud_rate = 1'b0;
  logic busy, overflow;

  uk101_load_sequencer_if bus();

  uk101_load_sequencer #(
    .CLK_HZ(48000),
    .FIFO_DEPTH(16),
    .CR_EXTRA_CYCLES(240)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .load_from(load_from),
    .baud_rate(baud_rate),
    .bus(bus),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int     tests = 0;
  int     failed = 0;
  longint cyc = 0;
  longint last_acc = 0;
  exp_t   sb[$];
  exp_t   mon_e;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every ACIA transfer is popped against the scoreboard.
  always @(negedge clk) begin
    if (n_reset && bus.rx_valid && bus.rx_ready) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_rx: actual %0h required none", bus.rx_data);
      end else begin
        mon_e = sb.pop_front();
        check("rx_data", bus.rx_data, mon_e.data);
        if (mon_e.spacing != 0) check("accept_spacing", cyc - last_acc, mon_e.spacing);
      end
      last_acc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input longint sp);
    exp_t e;
    e.data = d;
    e.spacing = sp;
    sb.push_back(e);
  endtask

  task automatic strobe(input logic [7:0] d);
    bus.ioctl_wr = 1'b1;
    bus.ioctl_data = d;
    tick(1);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      tick(1);
      n++;
    end
    check("busy_fall", busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rx_valid"}, bus.rx_valid, 0);
    check({tag, "_rx_data"}, bus.rx_data, 0);
    check({tag, "_ioctl_wait"}, bus.ioctl_wait, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  int  n;
  int  sent;
  int  guard;
  bit  seen;

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_data = '0;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data = '0;
    bus.rx_ready = 1'b0;
    tick(3);
    check_zero_outputs("reset");
    n_reset = 1'b1;
    tick(2);

    // File "AB" at 9600: latency, spacing, busy fall
    bus.rx_ready = 1'b1;
    bus.ioctl_download = 1'b1;
    tick(2);
    expect_byte(8'h41, 0);
    expect_byte(8'h42, G96 + 1);
    bus.ioctl_wr = 1'b1;
    bus.ioctl_data = 8'h41;
    tick(1);
    bus.ioctl_data = 8'h42;
    check("lat_n1_rx_valid", bus.rx_valid, 0);
    tick(1);
    bus.ioctl_wr = 1'b0;
    check("lat_n2_rx_valid", bus.rx_valid, 1);
    check("lat_n2_rx_data", bus.rx_data, 8'h41);
    bus.ioctl_download = 1'b0;
    wait_idle(500, n);
    check("ab_idle_cycles", n, 2 * G96 + 2);
    check("ab_sb_empty", sb.size(), 0);

    // CR at 300 baud gets the extra pause
    baud_rate = 1'b1;
    bus.ioctl_download = 1'b1;
    tick(2);
    expect_byte(8'h0D, 0);
    expect_byte(8'h5A, G3 + CRX + 1);
    strobe(8'h0D);
    strobe(8'h5A);
    bus.ioctl_download = 1'b0;
    wait_idle(5000, n);
    check("cr_sb_empty", sb.size(), 0);
    baud_rate = 1'b0;

    // "X\r\nY\n"
    bus.ioctl_download = 1'b1;
    tick(2);
`ifdef UK101_LF_TO_CR_EN
    expect_byte(8'h58, 0);
    expect_byte(8'h0D, G96 + 1);
    expect_byte(8'h59, 0);
    expect_byte(8'h0D, G96 + 1);
`else
    expect_byte(8'h58, 0);
    expect_byte(8'h0D, G96 + 1);
    expect_byte(8'h0A, G96 + CRX + 1);
    expect_byte(8'h59, G96 + 1);
    expect_byte(8'h0A, G96 + 1);
`endif
    strobe(8'h58);
    strobe(8'h0D);
    strobe(8'h0A);
    strobe(8'h59);
    strobe(8'h0A);
    bus.ioctl_download = 1'b0;
    wait_idle(3000, n);
    check("lf_sb_empty", sb.size(), 0);

    // Back-pressure honoured: 20 bytes, wait rises with 16 strobes issued
    bus.rx_ready = 1'b0;
    bus.ioctl_download = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) expect_byte(8'h80 + 8'(i), (i == 0) ? 0 : G96 + 1);
    sent = 0;
    seen = 1'b0;
    guard = 0;
    while (sent < 20 && guard < 3000) begin
      if (!seen && bus.ioctl_wait) begin
        seen = 1'b1;
        check("wait_rise_strobes", sent, 16);
        bus.rx_ready = 1'b1;
      end
      if (!bus.ioctl_wait) begin
        bus.ioctl_wr = 1'b1;
        bus.ioctl_data = 8'h80 + 8'(sent);
        sent++;
      end else begin
        bus.ioctl_wr = 1'b0;
      end
      tick(1);
      guard++;
    end
    bus.ioctl_wr = 1'b0;
    check("bp_all_sent", sent, 20);
    bus.ioctl_download = 1'b0;
    wait_idle(3000, n);
    check("bp_overflow", overflow, 0);
    check("bp_sb_empty", sb.size(), 0);

    // Ignoring ioctl_wait overflows; reset clears everything at once
    bus.rx_ready = 1'b0;
    bus.ioctl_download = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) strobe(8'hA0 + 8'(i));
    tick(1);
    check("ovf_set", overflow, 1);
    check("ovf_wait", bus.ioctl_wait, 1);
    n_reset = 1'b0;
    #1;
    check_zero_outputs("ovf_rst");
    tick(2);
    bus.ioctl_download = 1'b0;
    n_reset = 1'b1;
    tick(2);

    // Reset mid-gap with 3 bytes queued; nothing stale afterwards
    bus.rx_ready = 1'b1;
    bus.ioctl_download = 1'b1;
    tick(2);
    expect_byte(8'hC1, 0);
    strobe(8'hC1);
    strobe(8'hC2);
    strobe(8'hC3);
    strobe(8'hC4);
    tick(10);
    check("gap_busy", busy, 1);
    n_reset = 1'b0;
    #1;
    check_zero_outputs("gap_rst");
    tick(2);
    bus.ioctl_download = 1'b0;
    n_reset = 1'b1;
    tick(2);
    bus.ioctl_download = 1'b1;
    tick(150);
    bus.ioctl_download = 1'b0;
    wait_idle(500, n);
    check("gap_sb_empty", sb.size(), 0);

    // UART pass-through with a concurrent (ignored) file strobe
    load_from = 1'b1;
    tick(2);
    expect_byte(8'h55, 0);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data = 8'h55;
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr = 1'b1;
    bus.ioctl_data = 8'hEE;
    tick(1);
    bus.uart_rx_valid = 1'b0;
    bus.ioctl_wr = 1'b0;
    check("uart_rx_valid", bus.rx_valid, 1);
    check("uart_rx_data", bus.rx_data, 8'h55);
    tick(1);
    check("uart_one_cycle", bus.rx_valid, 0);
    check("uart_idle", busy, 0);
    check("uart_overflow", overflow, 0);
    bus.ioctl_download = 1'b0;
    load_from = 1'b0;
    tick(2);
    bus.ioctl_download = 1'b1;
    tick(100);
    bus.ioctl_download = 1'b0;
    wait_idle(500, n);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
